// File: rtl/text_console_writer.sv
// Byte-stream terminal writer for the 64x30 text-mode character buffer.
// Tracks a cursor, interprets LF/CR/BS/FF, and blank-sweeps the buffer after reset and on FF.
module text_console_writer #(
  parameter int unsigned COLS  = 64,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  output logic        wenable,
  output logic [15:0] waddr,
  output logic [15:0] wdata,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [5:0] ColMax = 6'(COLS - 1);
  localparam logic [4:0] RowMax = 5'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  clr_col_q, clr_col_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic        wen_q, wen_d;
  logic [15:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            wen_d   = 1'b1;
            waddr_d = {5'b0, row_q, col_q};
            wdata_d = {8'h00, in_char};
            state_d = StWrite;
            if (col_q == ColMax) begin
              col_d = 6'd0;
              row_d = (row_q == RowMax) ? 5'd0 : row_q + 5'd1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else begin
            case (in_char)
              8'h0A: begin
                col_d = 6'd0;
                row_d = (row_q == RowMax) ? 5'd0 : row_q + 5'd1;
              end
              8'h0D: col_d = 6'd0;
              8'h08: begin
                if (col_q != 6'd0) begin
                  col_d   = col_q - 6'd1;
                  wen_d   = 1'b1;
                  waddr_d = {5'b0, row_q, col_q - 6'd1};
                  wdata_d = {8'h00, BLANK};
                  state_d = StWrite;
                end else if (row_q != 5'd0) begin
                  row_d   = row_q - 5'd1;
                  col_d   = ColMax;
                  wen_d   = 1'b1;
                  waddr_d = {5'b0, row_q - 5'd1, ColMax};
                  wdata_d = {8'h00, BLANK};
                  state_d = StWrite;
                end
              end
              8'h0C: begin
                // The (0,0) blank goes out right away, so the sweep counter resumes at (0,1).
                col_d     = 6'd0;
                row_d     = 5'd0;
                wen_d     = 1'b1;
                waddr_d   = 16'h0000;
                wdata_d   = {8'h00, BLANK};
                clr_col_d = 6'd1;
                clr_row_d = 5'd0;
                state_d   = StClear;
              end
              default: ;
            endcase
          end
        end
      end
      StWrite: state_d = StIdle;
      StClear: begin
        // Finished once the last cell's write has been on the port for its cycle.
        if (wen_q && waddr_q[10:0] == {RowMax, ColMax}) begin
          state_d   = StIdle;
          clr_col_d = 6'd0;
          clr_row_d = 5'd0;
        end else begin
          wen_d   = 1'b1;
          waddr_d = {5'b0, clr_row_q, clr_col_q};
          wdata_d = {8'h00, BLANK};
          if (clr_col_q == ColMax) begin
            clr_col_d = 6'd0;
            clr_row_d = (clr_row_q == RowMax) ? 5'd0 : clr_row_q + 5'd1;
          end else begin
            clr_col_d = clr_col_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StClear;
      col_q     <= 6'd0;
      row_q     <= 5'd0;
      clr_col_q <= 6'd0;
      clr_row_q <= 5'd0;
      wen_q     <= 1'b0;
      waddr_q   <= 16'h0000;
      wdata_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q == StClear);
  assign wenable    = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
